bist_checker: RTL
=================

# bist_checker

Response checker sitting directly downstream of the deterministic pattern generators (`zero_one_patgen` and siblings) in the SRAM BIST path. It snoops the generator's request stream, delays expected data by the SRAM read latency, and compares it against the macro's read data. It reports a sticky fail flag, a saturating error count, the first failing address and data, and a completion flag once the generator finishes and the compare pipeline drains.

## Interface

- `MAX_ADDR`, 127: highest word address; address width `AW = $clog2(MAX_ADDR+1)`.
- `DATA_WIDTH`, 8: SRAM word width.
- `MASK_WIDTH`, 2: write-mask width; accepted for interface parity, not used by compare.
- `READ_LATENCY`, 1: edges from read request sample to read data sample; legal range 1..4.
- `ERR_WIDTH`, 16: error counter width.

- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  generator request valid.
- `we`  in  1  request is a write (1) or read (0).
- `addr`  in  AW  request address.
- `data`  in  DATA_WIDTH  on reads: expected data.
- `wmask`  in  MASK_WIDTH  ignored.
- `pg_done`  in  1  generator done flag.
- `dout`  in  DATA_WIDTH  SRAM read data.
- `fail`  out  1  sticky: any mismatch since reset.
- `err_count`  out  ERR_WIDTH  mismatches, saturating at all-ones.
- `first_addr`  out  AW  address of first mismatch.
- `first_exp`, `first_act`  out  DATA_WIDTH  expected/actual data of first mismatch.
- `check_done`  out  1  generator done and pipeline drained.

## Operation

- Read request: `en && !we` sampled high at edge k. Push {valid, addr, data} into a `READ_LATENCY`-deep delay line.
- Compare at edge k+READ_LATENCY using `dout` sampled at that edge; mismatch = `dout != expected` over full word.
- On mismatch: `fail`←1; `err_count` += 1 unless all-ones; if `fail` was 0, capture `first_addr/first_exp/first_act`. Later mismatches never overwrite captures.
- Writes (`en && we`) and idle cycles push invalid entries; never compared.
- FSM `IDLE → RUN → DRAIN → DONE`:
  - IDLE: after reset; to RUN on first `en`.
  - RUN: to DRAIN on edge sampling `pg_done`=1 (also legal directly from IDLE).
  - DRAIN: counts READ_LATENCY edges; requests still accepted and compared; to DONE when count expires.
  - DONE: `check_done`=1; holds until `rst`. Compares of entries still in flight continue; new requests ignored.
- Request with `pg_done` in same cycle is still checked.

## Timing

- Reset values: `fail`=0, `err_count`=0, `first_*`=0, `check_done`=0, delay line all invalid, FSM IDLE.
- `rst` mid-test: everything returns to reset values at that edge; in-flight reads discarded, never compared.
- Outputs registered; `fail`/`err_count` visible the cycle after compare edge (i.e. after edge k+READ_LATENCY).
- `check_done` rises after edge d+READ_LATENCY, d = edge first sampling `pg_done`.
- Back-to-back reads every cycle fully supported; throughput 1 compare/cycle.
- Counter saturation: at all-ones, further mismatches leave it unchanged; `fail` stays 1.

## Structure

- Package `bist_pkg`: `checker_state_t` enum (IDLE, RUN, DRAIN, DONE), `addr_width()` helper, max latency constant 4.
- Sub-module `bist_delay_line` (parameterised width and depth, synchronous clear) holds valid/addr/expected; checker FSM, compare and capture registers in top.

## Test plan

- Clean run, LATENCY=1: 128 writes then 128 reads, `dout` matches → `fail`=0, `err_count`=0, `check_done` one edge after `pg_done` sampled.
- Single fault: read of addr 0x2A expects 0xFF, `dout`=0xFB → `fail`=1, `err_count`=1, `first_addr`=0x2A, `first_exp`=0xFF, `first_act`=0xFB.
- Two faults at 0x05 then 0x10 → `err_count`=2, captures still 0x05 data.
- LATENCY=3, continuous reads, `dout` delayed 3 edges → no errors; skew by 1 edge → mismatches on every differing word.
- ERR_WIDTH=4, 20 mismatching reads → `err_count`=15, `fail`=1.
- Assert `rst` two cycles after a failing read issued (LATENCY=3) → all outputs 0, no late error recorded.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and helpers for the SRAM BIST response checker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: checker FSM state enum, address-width helper, and the
// largest supported SRAM read latency.
package bist_pkg;

    localparam int MAX_READ_LATENCY = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } checker_state_t;

    // Bits needed to hold word addresses 0..max_addr (at least 1).
    function automatic int addr_width(input int max_addr);
        return (max_addr < 1) ? 1 : $clog2(max_addr + 1);
    endfunction

endpackage

// File: rtl/bist_delay_line.sv
// Fixed-depth shift register that ages snooped read requests by the SRAM read latency.
// Latency: exactly DEPTH clk edges from i_dat to o_dat.
// Backpressure: none; shifts every cycle, synchronous clear empties every stage.
//
// Ports:
//   clk    - clock, rising edge
//   i_clr  - synchronous clear, zeroes all stages (valid bit included)
//   i_dat  - entry entering the line this edge
//   o_dat  - entry that entered DEPTH edges ago
module bist_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_dat;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_dat = r_stage[DEPTH-1];

endmodule

// File: rtl/bist_checker.sv
// SRAM BIST response checker: delays expected read data by the SRAM latency and compares it to dout.
// Latency: compare at edge k+READ_LATENCY for a read sampled at edge k; results visible one cycle later.
// Backpressure: none; one compare per cycle, requests are snooped and never stalled.
//
// Ports:
//   clk, rst                 - clock and synchronous active-high reset
//   en, we, addr, data       - generator request stream (data = expected word on reads)
//   wmask                    - write mask, carried for interface parity only
//   pg_done                  - generator finished
//   dout                     - SRAM read data
//   fail, err_count          - sticky fail flag, saturating mismatch counter
//   first_addr/exp/act       - capture of the first mismatch since reset
//   check_done               - generator finished and compare pipeline drained
module bist_checker
    import bist_pkg::*;
#(
    parameter int MAX_ADDR     = 127,
    parameter int DATA_WIDTH   = 8,
    parameter int MASK_WIDTH   = 2,
    parameter int READ_LATENCY = 1,   // 1..MAX_READ_LATENCY
    parameter int ERR_WIDTH    = 16,
    localparam int AW          = addr_width(MAX_ADDR)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [MASK_WIDTH-1:0] wmask,
    input  logic                  pg_done,
    input  logic [DATA_WIDTH-1:0] dout,
    output logic                  fail,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic [AW-1:0]         first_addr,
    output logic [DATA_WIDTH-1:0] first_exp,
    output logic [DATA_WIDTH-1:0] first_act,
    output logic                  check_done
);

    localparam int         EW         = 1 + AW + DATA_WIDTH;
    localparam logic [1:0] LAST_DRAIN = 2'(READ_LATENCY - 1);

    checker_state_t r_state;
    checker_state_t w_state_nxt;
    logic [1:0]     r_drain_cnt;
    logic [1:0]     w_drain_cnt_nxt;
    logic           r_check_done;

    logic                  w_push_vld;
    logic [EW-1:0]         w_push_dat;
    logic [EW-1:0]         w_pop_dat;
    logic                  w_pop_vld;
    logic [AW-1:0]         w_pop_addr;
    logic [DATA_WIDTH-1:0] w_pop_exp;
    logic                  w_mismatch;

    logic                  r_fail;
    logic [ERR_WIDTH-1:0]  r_err_count;
    logic [AW-1:0]         r_first_addr;
    logic [DATA_WIDTH-1:0] r_first_exp;
    logic [DATA_WIDTH-1:0] r_first_act;

    logic w_unused;
    assign w_unused = ^wmask;

    // Reads are tracked until the checker reaches DONE; after that the
    // generator is finished and any further requests are ignored.
    assign w_push_vld = en && !we && (r_state != DONE);
    assign w_push_dat = {w_push_vld, addr, data};

    bist_delay_line #(
        .WIDTH (EW),
        .DEPTH (READ_LATENCY)
    ) u_delay_line (
        .clk   (clk),
        .i_clr (rst),
        .i_dat (w_push_dat),
        .o_dat (w_pop_dat)
    );

    assign {w_pop_vld, w_pop_addr, w_pop_exp} = w_pop_dat;
    assign w_mismatch = w_pop_vld && (dout != w_pop_exp);

    // Control FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_drain_cnt  <= '0;
            r_check_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_drain_cnt  <= w_drain_cnt_nxt;
            r_check_done <= (w_state_nxt == DONE);
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        case (r_state)
            IDLE: begin
                if (pg_done) begin
                    w_state_nxt     = DRAIN;
                    w_drain_cnt_nxt = '0;
                end else if (en) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (pg_done) begin
                    w_state_nxt     = DRAIN;
                    w_drain_cnt_nxt = '0;
                end
            end
            DRAIN: begin
                // The last read can be sampled on the pg_done edge, so wait
                // READ_LATENCY more edges for its compare before declaring done.
                if (r_drain_cnt == LAST_DRAIN) begin
                    w_state_nxt = DONE;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt + 2'd1;
                end
            end
            default: begin
                w_state_nxt = DONE;
            end
        endcase
    end

    // Compare result and first-failure capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fail       <= 1'b0;
            r_err_count  <= '0;
            r_first_addr <= '0;
            r_first_exp  <= '0;
            r_first_act  <= '0;
        end else if (w_mismatch) begin
            r_fail <= 1'b1;
            if (r_err_count != '1) begin
                r_err_count <= r_err_count + ERR_WIDTH'(1);
            end
            if (!r_fail) begin
                r_first_addr <= w_pop_addr;
                r_first_exp  <= w_pop_exp;
                r_first_act  <= dout;
            end
        end
    end

    assign fail       = r_fail;
    assign err_count  = r_err_count;
    assign first_addr = r_first_addr;
    assign first_exp  = r_first_exp;
    assign first_act  = r_first_act;
    assign check_done = r_check_done;

endmodule
